ex_wb_pipe: RTL and testbench
=============================

EX_WB_PIPE -- requirements
Module: ex_wb_pipe

Interface
REQ-001 Parameter DW, default 16, datapath width.
REQ-002 Parameter LOAD_LAT, default 2, cycles a load occupies MEM; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  external hold of MEM stage.
REQ-006 flush  input  1  discard instruction presented from EX this cycle.
REQ-007 RA1_EX  input  4  destination register of EX instruction.
REQ-008 RegWrite_EX  input  1  EX instruction writes RA1.
REQ-009 R0W_EX  input  1  EX instruction also writes R0 (mul/div second result).
REQ-010 MemRead_EX  input  1  EX instruction is a load.
REQ-011 ALU_EX  input  DW  primary EX result / load address.
REQ-012 R0D_EX  input  DW  secondary EX result destined for R0.
REQ-013 MemData_MEM  input  DW  data memory read data, valid combinationally on final load cycle.
REQ-014 RA1_MEM, RegWrite_MEM, R0W_MEM, MemRead_MEM  output  4/1/1/1  registered MEM-stage control, consumed by forwarding unit.
REQ-015 ALU_MEM  output  DW  registered MEM-stage result (memory address).
REQ-016 RA1_WB, RegWrite_WB, R0W  output  4/1/1  registered WB-stage control, consumed by forwarding unit and register file.
REQ-017 WD_WB, R0D_WB  output  DW  registered WB write data for RA1 and R0.
REQ-018 busy_MEM  output  1  combinational; MEM stage is holding a load, upstream must stall.

Function
REQ-019 MEM register SHALL load from EX inputs on a clock edge when hold=0, where hold = stall | busy_MEM.
REQ-020 When hold=0 and flush=1, MEM SHALL load a bubble: RA1_MEM=0, all MEM control bits 0, ALU_MEM=0.
REQ-021 When hold=1, MEM register SHALL keep its contents; flush is ignored (hold has priority).
REQ-022 Internal counter lcnt (3 bits) SHALL load 1 when a load enters MEM, increment each cycle while MemRead_MEM=1 and lcnt<LOAD_LAT, and clear when the load leaves MEM.
REQ-023 busy_MEM SHALL equal MemRead_MEM & (lcnt < LOAD_LAT); with LOAD_LAT=1 busy_MEM is always 0.
REQ-024 External stall SHALL freeze lcnt; a load under stall does not advance its latency count.
REQ-025 WB register SHALL capture MEM contents on an edge where hold=0, with WD_WB = MemData_MEM if MemRead_MEM else ALU_MEM, R0D_WB = ALU-independent copy of MEM-stage R0 data.
REQ-026 When hold=1, WB SHALL load a bubble: RegWrite_WB=0, R0W=0, RA1_WB=0; WD_WB and R0D_WB hold.
REQ-027 Latency: non-load instruction SHALL appear in MEM 1 cycle and in WB 2 cycles after presentation at EX inputs; load appears in WB LOAD_LAT+1 cycles after entry with no external stall.
REQ-028 Instruction with MemRead_EX=1 and R0W_EX=1 is illegal; block SHALL treat R0W as 0 for loads.
REQ-029 Writes with RA1=0 and RegWrite=1 SHALL propagate unmodified; R0 conflict resolution belongs to the register file.

Reset
REQ-030 rst=1 at an edge SHALL clear every registered output and lcnt to 0, overriding stall and flush; busy_MEM is therefore 0 the cycle after reset.
REQ-031 Reset mid-load SHALL discard the load; no WB write occurs for it.

Verification
REQ-032 ALU op RA1_EX=5, RegWrite_EX=1, ALU_EX=0x1234 -> next cycle RA1_MEM=5, RegWrite_MEM=1; following cycle RA1_WB=5, RegWrite_WB=1, WD_WB=0x1234.
REQ-033 Load RA1_EX=8, MemRead_EX=1, LOAD_LAT=2, MemData_MEM=0xBEEF -> busy_MEM=1 for exactly 1 cycle, RegWrite_WB=0 that cycle, then RA1_WB=8, WD_WB=0xBEEF.
REQ-034 flush=1 with RegWrite_EX=1, RA1_EX=3 -> next cycle RegWrite_MEM=0, RA1_MEM=0; one cycle later RegWrite_WB=0.
REQ-035 Mul op RA1_EX=6, R0W_EX=1, R0D_EX=0x00FF, stall=1 for 2 cycles after entry -> MEM holds RA1_MEM=6, WB shows 2 bubbles (R0W=0), then R0W=1, R0D_WB=0x00FF.
REQ-036 stall=1 and flush=1 together with valid instruction in MEM -> MEM contents unchanged, WB bubble.
REQ-037 rst=1 during second cycle of load -> all outputs 0 next cycle, busy_MEM=0, no WB write for the load.

Source files
------------

// File: rtl/ex_wb_pipe_if.sv
// EX->MEM->WB pipeline bundle: EX-stage inputs, memory read data, and the
// registered MEM/WB stage state handed to the forwarding unit and register file.
interface ex_wb_pipe_if #(
    parameter int DW = 16
);
    logic          stall;
    logic          flush;
    logic [3:0]    RA1_EX;
    logic          RegWrite_EX;
    logic          R0W_EX;
    logic          MemRead_EX;
    logic [DW-1:0] ALU_EX;
    logic [DW-1:0] R0D_EX;
    logic [DW-1:0] MemData_MEM;

    logic [3:0]    RA1_MEM;
    logic          RegWrite_MEM;
    logic          R0W_MEM;
    logic          MemRead_MEM;
    logic [DW-1:0] ALU_MEM;

    logic [3:0]    RA1_WB;
    logic          RegWrite_WB;
    logic          R0W;
    logic [DW-1:0] WD_WB;
    logic [DW-1:0] R0D_WB;

    logic          busy_MEM;

    modport slave (
        input  stall, flush, RA1_EX, RegWrite_EX, R0W_EX, MemRead_EX,
               ALU_EX, R0D_EX, MemData_MEM,
        output RA1_MEM, RegWrite_MEM, R0W_MEM, MemRead_MEM, ALU_MEM,
               RA1_WB, RegWrite_WB, R0W, WD_WB, R0D_WB, busy_MEM
    );

    modport master (
        output stall, flush, RA1_EX, RegWrite_EX, R0W_EX, MemRead_EX,
               ALU_EX, R0D_EX, MemData_MEM,
        input  RA1_MEM, RegWrite_MEM, R0W_MEM, MemRead_MEM, ALU_MEM,
               RA1_WB, RegWrite_WB, R0W, WD_WB, R0D_WB, busy_MEM
    );
endinterface

// File: rtl/ex_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with a multi-cycle load hold in MEM.
// A load keeps MEM occupied for LOAD_LAT cycles; busy_MEM asks upstream to stall.
module ex_wb_pipe #(
    parameter int DW       = 16,
    parameter int LOAD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    ex_wb_pipe_if.slave  bus
);
    localparam logic [2:0] LAT = 3'(LOAD_LAT);

    logic [2:0]    lcnt;
    logic [DW-1:0] R0D_MEM;
    logic          busy;
    logic          hold;

    assign busy         = bus.MemRead_MEM & (lcnt < LAT);
    assign bus.busy_MEM = busy;
    assign hold         = bus.stall | busy;

    // EX -> MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RA1_MEM      <= '0;
            bus.RegWrite_MEM <= 1'b0;
            bus.R0W_MEM      <= 1'b0;
            bus.MemRead_MEM  <= 1'b0;
            bus.ALU_MEM      <= '0;
            R0D_MEM          <= '0;
        end else if (!hold) begin
            if (bus.flush) begin
                bus.RA1_MEM      <= '0;
                bus.RegWrite_MEM <= 1'b0;
                bus.R0W_MEM      <= 1'b0;
                bus.MemRead_MEM  <= 1'b0;
                bus.ALU_MEM      <= '0;
                R0D_MEM          <= '0;
            end else begin
                bus.RA1_MEM      <= bus.RA1_EX;
                bus.RegWrite_MEM <= bus.RegWrite_EX;
                // A load never carries a second R0 result.
                bus.R0W_MEM      <= bus.R0W_EX & ~bus.MemRead_EX;
                bus.MemRead_MEM  <= bus.MemRead_EX;
                bus.ALU_MEM      <= bus.ALU_EX;
                R0D_MEM          <= bus.R0D_EX;
            end
        end
    end

    // Load latency count: restarts on every MEM load, frozen by external stall
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt <= 3'd0;
        end else if (!hold) begin
            lcnt <= (!bus.flush && bus.MemRead_EX) ? 3'd1 : 3'd0;
        end else if (!bus.stall && busy) begin
            lcnt <= lcnt + 3'd1;
        end
    end

    // MEM -> WB
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RA1_WB      <= '0;
            bus.RegWrite_WB <= 1'b0;
            bus.R0W         <= 1'b0;
            bus.WD_WB       <= '0;
            bus.R0D_WB      <= '0;
        end else if (!hold) begin
            bus.RA1_WB      <= bus.RA1_MEM;
            bus.RegWrite_WB <= bus.RegWrite_MEM;
            bus.R0W         <= bus.R0W_MEM;
            bus.WD_WB       <= bus.MemRead_MEM ? bus.MemData_MEM : bus.ALU_MEM;
            bus.R0D_WB      <= R0D_MEM;
        end else begin
            // Bubble into WB; write data is left as is since nothing is enabled.
            bus.RA1_WB      <= '0;
            bus.RegWrite_WB <= 1'b0;
            bus.R0W         <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_wb_pipe.sv
// Bench for ex_wb_pipe: directed scenarios plus a randomized stream checked
// against a queue of expected WB writes and an independent busy model.
module tb_ex_wb_pipe;
    localparam int DW       = 16;
    localparam int LOAD_LAT = 2;
    localparam logic [DW-1:0] MEM_KEY = 16'hA5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_wb_pipe_if #(.DW(DW)) bus ();

    ex_wb_pipe #(.DW(DW), .LOAD_LAT(LOAD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Data memory: read data is a fixed scramble of the address.
    assign bus.MemData_MEM = bus.ALU_MEM ^ MEM_KEY;

    typedef struct {
        logic [3:0]    ra;
        logic          rw;
        logic          r0w;
        logic [DW-1:0] wd;
        logic [DW-1:0] r0d;
    } wb_t;

    wb_t sbq[$];
    int  n_vec  = 0;
    int  n_err  = 0;
    int  n_pops = 0;
    bit  mon_en = 1'b0;

    bit  m_load = 1'b0;
    int  m_rem  = 0;
    bit  m_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit st, input bit fl, input bit [3:0] ra, input bit rw,
                        input bit r0w, input bit mr, input bit [DW-1:0] alu,
                        input bit [DW-1:0] r0d);
        bus.stall       = st;
        bus.flush       = fl;
        bus.RA1_EX      = ra;
        bus.RegWrite_EX = rw;
        bus.R0W_EX      = r0w;
        bus.MemRead_EX  = mr;
        bus.ALU_EX      = alu;
        bus.R0D_EX      = r0d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nop(input bit st);
        step(st, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_RA1_MEM"}, bus.RA1_MEM, 0);
        chk({pfx, "_RegWrite_MEM"}, bus.RegWrite_MEM, 0);
        chk({pfx, "_R0W_MEM"}, bus.R0W_MEM, 0);
        chk({pfx, "_MemRead_MEM"}, bus.MemRead_MEM, 0);
        chk({pfx, "_ALU_MEM"}, bus.ALU_MEM, 0);
        chk({pfx, "_RA1_WB"}, bus.RA1_WB, 0);
        chk({pfx, "_RegWrite_WB"}, bus.RegWrite_WB, 0);
        chk({pfx, "_R0W"}, bus.R0W, 0);
        chk({pfx, "_WD_WB"}, bus.WD_WB, 0);
        chk({pfx, "_R0D_WB"}, bus.R0D_WB, 0);
        chk({pfx, "_busy"}, bus.busy_MEM, 0);
    endtask

    // Reference: accept into MEM, track remaining load cycles, queue WB writes.
    always @(posedge clk) begin
        if (rst) begin
            m_load = 1'b0;
            m_rem  = 0;
            sbq.delete();
        end else begin
            m_hold = bus.stall || (m_load && m_rem > 0);
            if (!m_hold) begin
                if (!bus.flush && bus.MemRead_EX) begin
                    m_load = 1'b1;
                    m_rem  = LOAD_LAT - 1;
                end else begin
                    m_load = 1'b0;
                    m_rem  = 0;
                end
                if (!bus.flush && (bus.RegWrite_EX || (bus.R0W_EX && !bus.MemRead_EX))) begin
                    wb_t e;
                    e.ra  = bus.RA1_EX;
                    e.rw  = bus.RegWrite_EX;
                    e.r0w = bus.R0W_EX && !bus.MemRead_EX;
                    e.wd  = bus.MemRead_EX ? (bus.ALU_EX ^ MEM_KEY) : bus.ALU_EX;
                    e.r0d = bus.R0D_EX;
                    sbq.push_back(e);
                end
            end else if (!bus.stall && m_rem > 0) begin
                m_rem--;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_MEM", bus.busy_MEM, (m_load && m_rem > 0));
            if (bus.RegWrite_WB || bus.R0W) begin
                if (sbq.size() == 0) begin
                    chk("wb_unexpected", {bus.RegWrite_WB, bus.R0W}, 0);
                end else begin
                    wb_t e;
                    e = sbq.pop_front();
                    n_pops++;
                    chk("sb_RA1_WB", bus.RA1_WB, e.ra);
                    chk("sb_RegWrite_WB", bus.RegWrite_WB, e.rw);
                    chk("sb_R0W", bus.R0W, e.r0w);
                    chk("sb_WD_WB", bus.WD_WB, e.wd);
                    if (e.r0w) chk("sb_R0D_WB", bus.R0D_WB, e.r0d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with garbage on the inputs
        step(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        nop(1'b0);
        nop(1'b0);
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // ALU op through MEM then WB
        step(1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        chk("alu_RA1_MEM", bus.RA1_MEM, 5);
        chk("alu_RegWrite_MEM", bus.RegWrite_MEM, 1);
        chk("alu_ALU_MEM", bus.ALU_MEM, 16'h1234);
        nop(1'b0);
        chk("alu_RA1_WB", bus.RA1_WB, 5);
        chk("alu_RegWrite_WB", bus.RegWrite_WB, 1);
        chk("alu_WD_WB", bus.WD_WB, 16'h1234);

        // Load: one busy cycle, WB bubble, then load data
        step(1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 16'h1B4A, 16'h0000);
        chk("ld_busy1", bus.busy_MEM, 1);
        chk("ld_MemRead_MEM", bus.MemRead_MEM, 1);
        chk("ld_RegWrite_WB1", bus.RegWrite_WB, 0);
        nop(1'b0);
        chk("ld_busy2", bus.busy_MEM, 0);
        chk("ld_RegWrite_WB2", bus.RegWrite_WB, 0);
        nop(1'b0);
        chk("ld_RA1_WB", bus.RA1_WB, 8);
        chk("ld_RegWrite_WB", bus.RegWrite_WB, 1);
        chk("ld_WD_WB", bus.WD_WB, 16'hBEEF);

        // Flush inserts a bubble
        step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000);
        chk("fl_RegWrite_MEM", bus.RegWrite_MEM, 0);
        chk("fl_RA1_MEM", bus.RA1_MEM, 0);
        chk("fl_ALU_MEM", bus.ALU_MEM, 0);
        nop(1'b0);
        chk("fl_RegWrite_WB", bus.RegWrite_WB, 0);

        // Mul with R0 result held by two stall cycles
        step(1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h00FF);
        chk("mul_RA1_MEM", bus.RA1_MEM, 6);
        chk("mul_R0W_MEM", bus.R0W_MEM, 1);
        nop(1'b1);
        chk("mul_hold1_RA1_MEM", bus.RA1_MEM, 6);
        chk("mul_hold1_R0W", bus.R0W, 0);
        nop(1'b1);
        chk("mul_hold2_RA1_MEM", bus.RA1_MEM, 6);
        chk("mul_hold2_R0W", bus.R0W, 0);
        nop(1'b0);
        chk("mul_R0W", bus.R0W, 1);
        chk("mul_R0D_WB", bus.R0D_WB, 16'h00FF);

        // Stall beats flush
        step(1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 16'h0777, 16'h0000);
        step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h0000);
        chk("sf_RA1_MEM", bus.RA1_MEM, 9);
        chk("sf_RegWrite_MEM", bus.RegWrite_MEM, 1);
        chk("sf_ALU_MEM", bus.ALU_MEM, 16'h0777);
        chk("sf_RegWrite_WB", bus.RegWrite_WB, 0);
        nop(1'b0);
        chk("sf_RA1_WB", bus.RA1_WB, 9);
        chk("sf_WD_WB", bus.WD_WB, 16'h0777);

        // Load flagged with R0W is treated as a plain load
        step(1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h3333);
        chk("ldr0_R0W_MEM", bus.R0W_MEM, 0);
        nop(1'b0);
        nop(1'b0);
        chk("ldr0_R0W", bus.R0W, 0);
        chk("ldr0_WD_WB", bus.WD_WB, 16'h0100 ^ MEM_KEY);

        // Write to RA1=0 passes unchanged
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0ABC, 16'h0000);
        nop(1'b0);
        chk("r0_RegWrite_WB", bus.RegWrite_WB, 1);
        chk("r0_WD_WB", bus.WD_WB, 16'h0ABC);

        // External stall freezes the load count
        step(1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000);
        nop(1'b1);
        chk("lds_busy1", bus.busy_MEM, 1);
        nop(1'b1);
        chk("lds_busy2", bus.busy_MEM, 1);
        nop(1'b0);
        chk("lds_busy3", bus.busy_MEM, 0);
        nop(1'b0);
        chk("lds_WD_WB", bus.WD_WB, 16'h0200 ^ MEM_KEY);

        // Reset in the second cycle of a load drops it
        step(1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000);
        chk("rld_busy", bus.busy_MEM, 1);
        rst = 1'b1;
        nop(1'b0);
        check_zero("rld");
        rst = 1'b0;
        nop(1'b0);
        chk("rld_RegWrite_WB1", bus.RegWrite_WB, 0);
        nop(1'b0);
        chk("rld_RegWrite_WB2", bus.RegWrite_WB, 0);

        // Random stream with stalls, flushes and loads
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 16'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 8; i++) nop(1'b0);
        chk("sb_drained", sbq.size(), 0);
        chk("sb_pops_seen", (n_pops > 20), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
